// File: rtl/ad9643_pkg.sv
// Shared register map, response codes and STATUS field layout for the AD9643 AXI-Lite control block.
package ad9643_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ID     = 2'd2;
  localparam logic [1:0] REG_SNAP   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CNT_W           = 16;
  localparam int STAT_CNT_LSB    = 0;
  localparam int STAT_CNT_MSB    = 15;
  localparam int STAT_READY_BIT  = 16;
  localparam int STAT_STICKY_BIT = 17;

  localparam int CTRL_OVF_CLR_BIT = 31;

  localparam logic [31:0] DEFAULT_ID = 32'h9643_0001;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ad9643_ovf_counter.sv
// Overflow event tracker: rising-edge detect on the ADC overflow level, saturating count, sticky flag.
// Clear wins over accumulated history but a coincident rising edge is still recorded (count=1, sticky=1).
module ad9643_ovf_counter
  import ad9643_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ovf,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sticky
);

  logic ovf_q;
  logic rise;

  assign rise = ovf & ~ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      ovf_q <= ovf;
      if (clr) begin
        count  <= rise ? CNT_W'(1) : '0;
        sticky <= rise;
      end else if (rise) begin
        if (count != '1) count <= count + 1'b1;
        sticky <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad9643_axil_ctrl.sv
// AXI4-Lite register bank for the AD9643 receiver: CTRL (RW), STATUS, ID and, with AD9643_SNAPSHOT_EN, SNAPSHOT at 0xC.
// Writes commit one cycle after AW and W are both held; reads respond the cycle after AR; one write and one read in flight.
module ad9643_axil_ctrl
  import ad9643_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH         = 14,
  parameter logic [31:0] ID_VALUE           = DEFAULT_ID
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            adc_or_i,
  input  logic                            adc_ready_i,
  input  logic [DATA_WIDTH-1:0]           adc_sample_a_i,
  input  logic [DATA_WIDTH-1:0]           adc_sample_b_i,
  output logic [31:0]                     ctrl_o
);

  // Readies stay low for the first cycle out of reset so nothing is accepted while reset is applied.
  logic        active;

  logic        aw_held;
  logic        w_held;
  logic [1:0]  aw_sel;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [30:0] ctrl_q;

  logic             do_write;
  logic [31:0]      ctrl_merged;
  logic [30:0]      ctrl_next;
  logic [1:0]       wr_resp;
  logic             ovf_clr;
  logic [CNT_W-1:0] ovf_count;
  logic             ovf_sticky;
  logic [31:0]      status_word;
  logic [31:0]      rd_word;
  logic [1:0]       rd_resp;
  logic             unused_bits;

  assign s_axi_awready = active && !aw_held && !bvalid_q;
  assign s_axi_wready  = active && !w_held && !bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = active && !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_o        = {1'b0, ctrl_q};

  assign do_write = aw_held && w_held;

`ifdef AD9643_SNAPSHOT_EN
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                         s_axi_araddr[1:0], ctrl_merged[31]};
`else
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                         s_axi_araddr[1:0], ctrl_merged[31],
                         adc_sample_a_i, adc_sample_b_i};
`endif

  always_comb begin
    ctrl_merged = apply_wstrb({1'b0, ctrl_q}, wdata_q, wstrb_q);
    ctrl_next   = ctrl_q;
    wr_resp     = RESP_OKAY;
    ovf_clr     = 1'b0;
    if (do_write) begin
      case (aw_sel)
        REG_CTRL: begin
          ctrl_next = ctrl_merged[30:0];
          ovf_clr   = wstrb_q[3] & wdata_q[CTRL_OVF_CLR_BIT];
        end
        REG_SNAP: begin
`ifdef AD9643_SNAPSHOT_EN
          wr_resp = RESP_OKAY;
`else
          wr_resp = RESP_SLVERR;
`endif
        end
        default: wr_resp = RESP_OKAY;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      active   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      ctrl_q   <= '0;
    end else begin
      active <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_sel  <= s_axi_awaddr[3:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (do_write) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        ctrl_q   <= ctrl_next;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  ad9643_ovf_counter u_ovf (
    .clk    (s_axi_aclk),
    .rst_n  (s_axi_aresetn),
    .ovf    (adc_or_i),
    .clr    (ovf_clr),
    .count  (ovf_count),
    .sticky (ovf_sticky)
  );

  always_comb begin
    status_word                             = '0;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB]  = ovf_count;
    status_word[STAT_READY_BIT]             = adc_ready_i;
    status_word[STAT_STICKY_BIT]            = ovf_sticky;

    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_araddr[3:2])
      REG_CTRL:   rd_word = {1'b0, ctrl_q};
      REG_STATUS: rd_word = status_word;
      REG_ID:     rd_word = ID_VALUE;
      default: begin
`ifdef AD9643_SNAPSHOT_EN
        rd_word = {2'b00, adc_sample_b_i, 2'b00, adc_sample_a_i};
`else
        rd_resp = RESP_SLVERR;
`endif
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad9643_axil_ctrl.sv
// Directed self-checking bench for ad9643_axil_ctrl; expectations adapt to AD9643_SNAPSHOT_EN.
module tb_ad9643_axil_ctrl;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn = 1'b0;
  logic [3:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        adc_or_i = 1'b0;
  logic        adc_ready_i = 1'b1;
  logic [13:0] adc_sample_a_i = 14'h1ABC;
  logic [13:0] adc_sample_b_i = 14'h0123;
  logic [31:0] ctrl_o;

  int errors = 0;
  int checks = 0;

  always #5 s_axi_aclk = ~s_axi_aclk;

  ad9643_axil_ctrl dut (
    .s_axi_aclk     (s_axi_aclk),
    .s_axi_aresetn  (s_axi_aresetn),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awprot   (s_axi_awprot),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arprot   (s_axi_arprot),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .adc_or_i       (adc_or_i),
    .adc_ready_i    (adc_ready_i),
    .adc_sample_a_i (adc_sample_a_i),
    .adc_sample_b_i (adc_sample_b_i),
    .ctrl_o         (ctrl_o)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int aw_dly, input int w_dly, input int br_dly,
                    output logic [1:0] resp, output int bcycles, output int extra);
    bit aw_done, w_done, b_done;
    int c;
    aw_done = 0; w_done = 0; b_done = 0; c = 0;
    bcycles = 0; extra = 0; resp = 2'bxx;
    while (!b_done && c < 60) begin
      @(negedge s_axi_aclk);
      s_axi_awaddr  = addr;
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = !w_done && (c >= w_dly);
      s_axi_bready  = s_axi_bvalid && (bcycles >= br_dly);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      if (s_axi_bvalid) begin
        bcycles++;
        resp = s_axi_bresp;
        if (s_axi_bready) b_done = 1;
      end
      c++;
    end
    @(negedge s_axi_aclk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
    for (int i = 0; i < 3; i++) begin
      if (s_axi_bvalid) extra++;
      @(negedge s_axi_aclk);
    end
    checks++;
    if (!b_done) begin
      errors++;
      $display("FAIL wr_timeout addr=%h: no write response within 60 cycles", addr);
    end
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, done;
    int c;
    ar_done = 0; done = 0; c = 0; data = 'x; resp = 2'bxx;
    while (!done && c < 60) begin
      @(negedge s_axi_aclk);
      s_axi_araddr  = addr;
      s_axi_arvalid = !ar_done;
      s_axi_rready  = s_axi_rvalid;
      if (s_axi_rvalid) begin
        data = s_axi_rdata;
        resp = s_axi_rresp;
        done = 1;
      end
      if (s_axi_arvalid && s_axi_arready) ar_done = 1;
      c++;
    end
    @(negedge s_axi_aclk);
    s_axi_arvalid = 0; s_axi_rready = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rd_timeout addr=%h: no read data within 60 cycles", addr);
    end
  endtask

  task automatic pulse_ovf(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge s_axi_aclk); adc_or_i = 1;
      @(negedge s_axi_aclk);
      @(negedge s_axi_aclk); adc_or_i = 0;
      @(negedge s_axi_aclk);
    end
    @(negedge s_axi_aclk);
  endtask

  task automatic test_reset;
    s_axi_aresetn = 0;
    repeat (3) @(negedge s_axi_aclk);
    checks++; if (s_axi_awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", s_axi_awready); end
    checks++; if (s_axi_wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", s_axi_wready); end
    checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", s_axi_arready); end
    checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", s_axi_bvalid); end
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", s_axi_rvalid); end
    checks++; if (s_axi_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", s_axi_rdata); end
    checks++; if ({s_axi_bresp, s_axi_rresp} !== 4'b0) begin errors++; $display("FAIL rst_resp got %b want 0000", {s_axi_bresp, s_axi_rresp}); end
    checks++; if (ctrl_o !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h want 0", ctrl_o); end
    s_axi_aresetn = 1;
    repeat (2) @(negedge s_axi_aclk);
    checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready got aw=%b ar=%b want 1 1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_ctrl_rw;
    logic [1:0] resp; logic [31:0] d; int bc, ex;
    wr(4'h0, 32'h0123_4561, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL ctrl_bresp got %b want 00", resp); end
    checks++; if (ctrl_o !== 32'h0123_4561) begin errors++; $display("FAIL ctrl_o got %h want 01234561", ctrl_o); end
    rd(4'h0, d, resp);
    checks++; if (d !== 32'h0123_4561 || resp !== 2'b00) begin errors++; $display("FAIL ctrl_read got %h/%b want 01234561/00", d, resp); end
  endtask

  task automatic test_ovf_clr_bit;
    logic [1:0] resp; logic [31:0] d; int bc, ex;
    wr(4'h0, 32'h89AB_CDE2, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (ctrl_o !== 32'h09AB_CDE2) begin errors++; $display("FAIL ctrl_selfclr got %h want 09abcde2", ctrl_o); end
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0001_0000 || resp !== 2'b00) begin errors++; $display("FAIL status_idle got %h/%b want 00010000/00", d, resp); end
  endtask

  task automatic test_overflow;
    logic [1:0] resp; logic [31:0] d; int bc, ex;
    pulse_ovf(2);
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0003_0002) begin errors++; $display("FAIL status_two_ovf got %h want 00030002", d); end
    wr(4'h0, 32'h8000_0000, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (ctrl_o !== 32'h0) begin errors++; $display("FAIL ctrl_after_clr got %h want 0", ctrl_o); end
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL status_cleared got %h want 00010000", d); end
  endtask

  task automatic test_clear_collision;
    logic [1:0] resp; logic [31:0] d;
    pulse_ovf(3);
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0003_0003) begin errors++; $display("FAIL status_three_ovf got %h want 00030003", d); end
    @(negedge s_axi_aclk);
    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h8000_0000; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge s_axi_aclk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; adc_or_i = 1;
    @(negedge s_axi_aclk);
    checks++; if (s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL collide_bvalid got %b want 1", s_axi_bvalid); end
    s_axi_bready = 1;
    @(negedge s_axi_aclk);
    s_axi_bready = 0; adc_or_i = 0;
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0003_0001) begin errors++; $display("FAIL collide_status got %h want 00030001", d); end
  endtask

  task automatic test_strobes_skew;
    logic [1:0] resp; logic [31:0] d; int bc, ex;
    wr(4'h0, 32'hFFFF_FFFF, 4'h1, 0, 3, 0, resp, bc, ex);
    checks++; if (ctrl_o !== 32'h0000_00FF) begin errors++; $display("FAIL aw_first_strb got %h want 000000ff", ctrl_o); end
    checks++; if (bc !== 1 || ex !== 0) begin errors++; $display("FAIL aw_first_bcount got %0d/%0d want 1/0", bc, ex); end
    wr(4'h0, 32'hFFFF_FFFF, 4'h2, 3, 0, 0, resp, bc, ex);
    checks++; if (ctrl_o !== 32'h0000_FFFF) begin errors++; $display("FAIL w_first_strb got %h want 0000ffff", ctrl_o); end
    checks++; if (bc !== 1 || ex !== 0) begin errors++; $display("FAIL w_first_bcount got %0d/%0d want 1/0", bc, ex); end
    wr(4'h0, 32'h7F00_0000, 4'h8, 0, 0, 5, resp, bc, ex);
    checks++; if (bc !== 6 || ex !== 0) begin errors++; $display("FAIL bready_hold got %0d/%0d want 6/0", bc, ex); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL bready_hold_resp got %b want 00", resp); end
    rd(4'h0, d, resp);
    checks++; if (d !== 32'h7F00_FFFF) begin errors++; $display("FAIL strb_read got %h want 7f00ffff", d); end
  endtask

  task automatic test_regs;
    logic [1:0] resp; logic [31:0] d; int bc, ex;
    logic [31:0] exp_snap; logic [1:0] exp_snap_rresp, exp_snap_bresp;
`ifdef AD9643_SNAPSHOT_EN
    exp_snap = 32'h0123_1ABC; exp_snap_rresp = 2'b00; exp_snap_bresp = 2'b00;
`else
    exp_snap = 32'h0; exp_snap_rresp = 2'b10; exp_snap_bresp = 2'b10;
`endif
    rd(4'h8, d, resp);
    checks++; if (d !== 32'h9643_0001 || resp !== 2'b00) begin errors++; $display("FAIL id_read got %h/%b want 96430001/00", d, resp); end
    rd(4'hC, d, resp);
    checks++; if (d !== exp_snap || resp !== exp_snap_rresp) begin errors++; $display("FAIL off_c_read got %h/%b want %h/%b", d, resp, exp_snap, exp_snap_rresp); end
    wr(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL status_wr_resp got %b want 00", resp); end
    wr(4'h8, 32'h0, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL id_wr_resp got %b want 00", resp); end
    wr(4'hC, 32'h0, 4'hF, 0, 0, 0, resp, bc, ex);
    checks++; if (resp !== exp_snap_bresp) begin errors++; $display("FAIL off_c_wr_resp got %b want %b", resp, exp_snap_bresp); end
    checks++; if (ctrl_o !== 32'h7F00_FFFF) begin errors++; $display("FAIL ctrl_untouched got %h want 7f00ffff", ctrl_o); end
  endtask

  task automatic test_reset_mid_txn;
    logic [1:0] resp; logic [31:0] d;
    pulse_ovf(1);
    @(negedge s_axi_aclk);
    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge s_axi_aclk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge s_axi_aclk);
    checks++; if (s_axi_bvalid !== 1'b1 || ctrl_o !== 32'h55) begin errors++; $display("FAIL pend_b got %b/%h want 1/00000055", s_axi_bvalid, ctrl_o); end
    s_axi_aresetn = 0;
    @(negedge s_axi_aclk);
    checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL midrst_bvalid got %b want 0", s_axi_bvalid); end
    checks++; if (ctrl_o !== 32'h0) begin errors++; $display("FAIL midrst_ctrl got %h want 0", ctrl_o); end
    s_axi_aresetn = 1;
    repeat (4) @(negedge s_axi_aclk);
    checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL midrst_noresp got %b want 0", s_axi_bvalid); end
    rd(4'h4, d, resp);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL midrst_status got %h want 00010000", d); end
  endtask

  initial begin
    test_reset;
    test_ctrl_rw;
    test_ovf_clr_bit;
    test_overflow;
    test_clear_collision;
    test_strobes_skew;
    test_regs;
    test_reset_mid_txn;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9643_axil_ctrl.md
Name: ad9643_axil_ctrl

Overview:
- AXI4-Lite slave register bank for the AD9643 dual-channel LVDS ADC receiver.
- Holds the capture control word and reports ADC ready/overflow status.
- Sits between the processor AXI-Lite bus and the ADC datapath.
- All ADC-side inputs are already synchronised into s_axi_aclk; the block has no CDC logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported).
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select a register.
- DATA_WIDTH, 14, ADC sample width.
- ID_VALUE, 32'h96430001, constant returned by the ID register.

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_aresetn  in  1  synchronous, active-low reset.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- adc_or_i  in  1  ADC overflow level, synchronised.
- adc_ready_i  in  1  ADC datapath locked/ready.
- adc_sample_a_i, adc_sample_b_i  in  DATA_WIDTH  latest channel A/B samples.
- ctrl_o  out  32  CTRL register contents (bit31 always 0).

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL: RW. Bit31 is OVF_CLR, a self-clearing pulse that always reads 0.
  - 0x4 STATUS: RO. [15:0] overflow event count (saturating at 0xFFFF); [16] adc_ready_i live; [17] overflow sticky; rest 0.
  - 0x8 ID: RO, returns ID_VALUE.
  - 0xC: see Optional Feature.
- Reset (s_axi_aresetn=0 at clock edge): all ready/valid outputs 0; bresp/rresp 0; rdata 0; CTRL 0; count 0; sticky 0; edge-detect register 0.
- Write channel:
  - awready and wready each assert independently while their channel is not yet captured and bvalid=0.
  - Address and data are latched on their own handshakes, in either order or in the same cycle.
  - The register is updated one cycle after both are held; bvalid asserts in that same cycle.
  - bvalid holds until bready; no new AW/W is accepted while bvalid=1.
  - Only one write is outstanding at a time.
- Write rules:
  - wstrb[n] gates byte n; the write affects CTRL only.
  - Writes to STATUS or ID are ignored, bresp=OKAY (00).
  - Writes to an unmapped offset are ignored, bresp=SLVERR (10).
- Read channel:
  - arready=1 when rvalid=0.
  - On the AR handshake, rdata/rresp are registered and rvalid asserts next cycle.
  - rvalid holds until rready; there is no read/write arbitration hazard because the paths are independent.
  - An unmapped read returns rdata=0, rresp=SLVERR.
- Overflow logic:
  - A rising edge of adc_or_i (registered previous value 0, current 1) increments the count (saturating) and sets sticky.
  - Writing CTRL with bit31=1 (with wstrb[3]=1) clears count and sticky on the update cycle.
  - If a rising edge occurs in the same cycle as the clear, the result is count=1, sticky=1.
- A reset asserted mid-transaction aborts it: no response is issued and everything returns to reset values.

Optional Feature:
- Macro AD9643_SNAPSHOT_EN.
- Defined: offset 0xC is SNAPSHOT (RO), rdata = {2'b0, adc_sample_b_i, 2'b0, adc_sample_a_i}, sampled in the AR handshake cycle, rresp=OKAY.
- Undefined: 0xC is unmapped (read 0/SLVERR, write SLVERR).

Decomposition:
- Package ad9643_pkg: register offset localparams (CTRL/STATUS/ID/SNAP), response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, the STATUS bit-field positions, and DEFAULT_ID.
- One natural sub-module: ad9643_ovf_counter (edge detect, saturating counter, sticky, clear priority).
- The AXI handshake logic stays in the top module.

Test Plan:
- Write 0x01234561 to 0x0 -> bresp=00, ctrl_o=0x01234561; read 0x0 -> 0x01234561.
- Write 0x89ABCDE2 to 0x0 -> ctrl_o=0x09ABCDE2 (OVF_CLR self-clears); read 0x4 with adc_ready_i=1 and no overflow -> 0x00010000.
- Pulse adc_or_i high twice (each pulse 2 clocks) -> read 0x4 = 0x00030002 (ready, sticky, count 2); write 0x80000000 -> read 0x4 = 0x00010000.
- AW presented 3 cycles before W, and W before AW, with wstrb=0x1 data 0xFFFFFFFF -> only byte 0 changes; exactly one bvalid per write; bready held low 5 cycles -> bvalid stays asserted.
- Read 0x8 -> 0x96430001; read 0xC without macro -> 0/SLVERR; with macro, sample_a=0x1ABC, sample_b=0x0123 -> 0x01231ABC.
- Assert reset during a pending bvalid -> bvalid drops, ctrl_o=0, count=0 after the reset edge.
